// File: rtl/lp_serial_rx_pkg.sv
// Shared definitions for the LogicProbe serial receiver: byte-FSM state
// encoding, default line parameters shared with the transmitter, and helpers.
package lp_serial_rx_pkg;

  // Default line parameters, kept in step with the LogicProbe transmitter
  localparam int LP_CLK_FREQ    = 50000000;
  localparam int LP_BAUD        = 115200;

  // Depth of the rs232_rxd metastability synchroniser
  localparam int LP_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Number of bytes making up one sample word
  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/lp_uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, bit timer and byte FSM.
// byte_done / frame_err are single-cycle strobes raised in the cycle the stop
// bit is sampled, so the word assembler can act on the same clock edge.
module lp_uart_rx_byte
  import lp_serial_rx_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_err,
  output logic       line_idle
);

  localparam int              TW         = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0]   TIMER_HALF = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0]   TIMER_FULL = TW'(DIV - 1);

  logic [LP_SYNC_STAGES-1:0] sync_reg;
  logic                      rxd_s;

  rx_state_t     state_reg,    state_next;
  logic [TW-1:0] timer_reg,    timer_next;
  logic [2:0]    bit_idx_reg,  bit_idx_next;
  logic [7:0]    data_sr_reg,  data_sr_next;
  logic          wait_high_reg, wait_high_next;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_reg <= '1;
    else          sync_reg <= {sync_reg[LP_SYNC_STAGES-2:0], rxd};
  end

  assign rxd_s = sync_reg[LP_SYNC_STAGES-1];

  // FSM, bit timer and data shift register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      bit_idx_reg   <= '0;
      data_sr_reg   <= '0;
      wait_high_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      bit_idx_reg   <= bit_idx_next;
      data_sr_reg   <= data_sr_next;
      wait_high_reg <= wait_high_next;
    end
  end

  // Next-state logic: start-bit qualification at mid-bit, then one sample per bit time
  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    bit_idx_next   = bit_idx_reg;
    data_sr_next   = data_sr_reg;
    wait_high_next = wait_high_reg;
    byte_done      = 1'b0;
    frame_err      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        timer_next   = '0;
        bit_idx_next = '0;
        if (wait_high_reg) begin
          // After a framing error a held-low line must return high before a new start
          if (rxd_s) wait_high_next = 1'b0;
        end else if (!rxd_s) begin
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (timer_reg == TIMER_HALF) begin
          timer_next = '0;
          // Line back high at mid start bit: treat as a glitch, silently
          state_next = rxd_s ? ST_IDLE : ST_DATA;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      ST_DATA: begin
        if (timer_reg == TIMER_FULL) begin
          timer_next   = '0;
          data_sr_next = {rxd_s, data_sr_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = ST_STOP;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      ST_STOP: begin
        if (timer_reg == TIMER_FULL) begin
          timer_next = '0;
          state_next = ST_IDLE;
          if (rxd_s) begin
            byte_done = 1'b1;
          end else begin
            frame_err      = 1'b1;
            wait_high_next = 1'b1;
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign rx_byte   = data_sr_reg;
  assign line_idle = (state_reg == ST_IDLE) && rxd_s && !wait_high_reg;

endmodule

// File: rtl/lp_serial_rx.sv
// LogicProbe dump-stream receiver: regroups received bytes (first byte most
// significant) into WIDTH-bit sample words and offers them on valid/ready.
module lp_serial_rx
  import lp_serial_rx_pkg::*;
#(
  parameter int CLK_FREQ  = LP_CLK_FREQ,
  parameter int BAUD      = LP_BAUD,
  parameter int WIDTH     = 128,
  parameter int IDLE_BITS = 20
) (
  input  logic             clk,
  input  logic             reset_in_n,
  input  logic             rs232_rxd,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int             DIV       = CLK_FREQ / BAUD;
  localparam int             NBYTES    = bytes_per_word(WIDTH);
  localparam int             CW        = $clog2(NBYTES + 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(NBYTES - 1);
  localparam int             IDLE_CLKS = IDLE_BITS * DIV;
  localparam int             IW        = $clog2(IDLE_CLKS + 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_CLKS - 1);

  logic [7:0]       rx_byte;
  logic             byte_done;
  logic             byte_frame_err;
  logic             line_idle;

  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] word_sr_reg;
  logic [IW-1:0]    idle_cnt_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             data_valid_reg;
  logic             frame_err_reg;
  logic             overrun_reg;

  logic             word_done;
  logic [WIDTH-1:0] word_next;

  lp_uart_rx_byte #(
    .DIV (DIV)
  ) u_byte (
    .clk       (clk),
    .reset_n   (reset_in_n),
    .rxd       (rs232_rxd),
    .rx_byte   (rx_byte),
    .byte_done (byte_done),
    .frame_err (byte_frame_err),
    .line_idle (line_idle)
  );

  // The completing byte is merged combinationally so the word is ready on the stop-sample edge
  assign word_done = byte_done && (count_reg == CNT_LAST);
  assign word_next = (word_sr_reg << 8) | WIDTH'(rx_byte);

  // Byte counter, word shift register and mid-word idle timeout
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      count_reg    <= '0;
      word_sr_reg  <= '0;
      idle_cnt_reg <= '0;
    end else begin
      if (byte_frame_err) begin
        count_reg    <= '0;
        idle_cnt_reg <= '0;
      end else if (byte_done) begin
        word_sr_reg  <= word_next;
        count_reg    <= word_done ? '0 : count_reg + CW'(1);
        idle_cnt_reg <= '0;
      end else if ((count_reg != '0) && line_idle) begin
        // A long quiet line mid-word means the sender restarted: drop the partial word
        if (idle_cnt_reg == IDLE_LAST) begin
          count_reg    <= '0;
          idle_cnt_reg <= '0;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + IW'(1);
        end
      end else begin
        idle_cnt_reg <= '0;
      end
    end
  end

  // Holding register and valid/ready handshake; an unconsumed word is never overwritten
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_err_reg <= byte_frame_err;
      overrun_reg   <= 1'b0;
      if (word_done) begin
        if (!data_valid_reg || data_ready) begin
          data_out_reg   <= word_next;
          data_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (data_valid_reg && data_ready) begin
        data_valid_reg <= 1'b0;
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_lp_serial_rx.sv
// Randomised bench for lp_serial_rx at DIV=16 with a byte-stream reference model.
`timescale 1ns/1ps
module tb_lp_serial_rx;

  localparam int CLK_FREQ  = 1600000;
  localparam int BAUD      = 100000;
  localparam int DIV       = CLK_FREQ / BAUD;
  localparam int WIDTH     = 128;
  localparam int IDLE_BITS = 20;
  localparam int NB        = WIDTH / 8;

  logic             clk = 1'b0;
  logic             reset_in_n = 1'b0;
  logic             rs232_rxd = 1'b1;
  logic             data_ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             overrun;

  always #5 clk = ~clk;

  lp_serial_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .WIDTH     (WIDTH),
    .IDLE_BITS (IDLE_BITS)
  ) dut (
    .clk        (clk),
    .reset_in_n (reset_in_n),
    .rs232_rxd  (rs232_rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;
  int words_rx = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  // Reference model: pending bytes of the current word, and predicted words
  logic [7:0]       part_q[$];
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [WIDTH-1:0] w;
    part_q.push_back(b);
    if (part_q.size() == NB) begin
      w = '0;
      foreach (part_q[i]) w = {w[WIDTH-9:0], part_q[i]};
      exp_q.push_back(w);
      part_q.delete();
    end
  endtask

  task automatic model_clear();
    part_q.delete();
  endtask

  // Advance n clocks and leave inputs changing just after the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serialise one 8N1 byte; narrow=1 holds each data bit only within +-1 clk of its centre
  task automatic send_byte(input logic [7:0] b, input logic good_stop, input logic narrow);
    rs232_rxd = 1'b0;
    step(DIV);
    for (int i = 0; i < 8; i++) begin
      if (narrow) begin
        for (int k = 0; k < DIV; k++) begin
          rs232_rxd = (k >= DIV/2 - 1 && k <= DIV/2 + 1) ? b[i] : ~b[i];
          step(1);
        end
      end else begin
        rs232_rxd = b[i];
        step(DIV);
      end
    end
    rs232_rxd = good_stop;
    step(DIV);
    rs232_rxd = 1'b1;
  endtask

  task automatic send_rand(input int n, input logic narrow);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      model_byte(b);
      send_byte(b, 1'b1, narrow);
    end
  endtask

  // Monitor: one line per accepted word, checked against the model's next word
  always @(negedge clk) begin
    if (reset_in_n) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (data_valid && data_ready) begin
        words_rx++;
        $display("rx word %0d: %h", words_rx, data_out);
        check("word_expected", WIDTH'(exp_q.size() > 0), WIDTH'(1));
        if (exp_q.size() > 0) check("word_data", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fe0, ov0;
    logic [7:0] t1 [NB];
    logic [WIDTH-1:0] prev;

    t1 = '{8'hC7, 8'h03, 8'h37, 8'hDB, 8'h7F, 8'h4D, 8'h51, 8'h4F,
           8'h75, 8'h37, 8'h75, 8'h99, 8'h7D, 8'h59, 8'h37, 8'hA3};

    // Reset state
    data_ready = 1'b1;
    step(3);
    check("rst_data_out",   data_out,          WIDTH'(0));
    check("rst_data_valid", WIDTH'(data_valid), WIDTH'(0));
    check("rst_frame_err",  WIDTH'(frame_err),  WIDTH'(0));
    check("rst_overrun",    WIDTH'(overrun),    WIDTH'(0));
    reset_in_n = 1'b1;
    step(4);

    // 1: fixed 16-byte word
    base = words_rx;
    foreach (t1[i]) begin
      model_byte(t1[i]);
      send_byte(t1[i], 1'b1, 1'b0);
    end
    step(4);
    check("t1_words", WIDTH'(words_rx - base), WIDTH'(1));
    check("t1_data",  data_out, 128'hC70337DB7F4D514F753775997D5937A3);
    check("t1_valid_dropped", WIDTH'(data_valid), WIDTH'(0));

    // 2: short low glitch on an idle line
    fe0 = fe_cnt;
    base = words_rx;
    rs232_rxd = 1'b0;
    step(DIV / 4);
    rs232_rxd = 1'b1;
    step(3 * DIV);
    check("t2_no_frame_err", WIDTH'(fe_cnt - fe0), WIDTH'(0));
    send_rand(NB, 1'b0);
    step(4);
    check("t2_words", WIDTH'(words_rx - base), WIDTH'(1));

    // 3: framing error after 5 good bytes discards the partial word
    fe0 = fe_cnt;
    base = words_rx;
    send_rand(5, 1'b0);
    model_clear();
    send_byte(8'h55, 1'b0, 1'b0);
    step(DIV);
    check("t3_frame_err", WIDTH'(fe_cnt - fe0), WIDTH'(1));
    send_rand(NB, 1'b0);
    step(4);
    check("t3_words", WIDTH'(words_rx - base), WIDTH'(1));
    check("t3_queue", WIDTH'(exp_q.size()), WIDTH'(0));

    // 4: consumer stalled across two words
    data_ready = 1'b0;
    ov0 = ov_cnt;
    base = words_rx;
    send_rand(2 * NB, 1'b0);
    step(4);
    void'(exp_q.pop_back());
    check("t4_overrun", WIDTH'(ov_cnt - ov0), WIDTH'(1));
    check("t4_valid_held", WIDTH'(data_valid), WIDTH'(1));
    if (exp_q.size() > 0) prev = exp_q[0];
    else prev = '0;
    check("t4_first_kept", data_out, prev);
    data_ready = 1'b1;
    step(1);
    data_ready = 1'b0;
    step(1);
    check("t4_valid_dropped", WIDTH'(data_valid), WIDTH'(0));
    check("t4_words", WIDTH'(words_rx - base), WIDTH'(1));
    check("t4_data_kept", data_out, prev);
    data_ready = 1'b1;

    // 5: idle resync mid-word
    base = words_rx;
    send_rand(7, 1'b0);
    step(DIV * (IDLE_BITS + 1));
    model_clear();
    send_rand(NB, 1'b0);
    step(4);
    check("t5_words", WIDTH'(words_rx - base), WIDTH'(1));
    check("t5_queue", WIDTH'(exp_q.size()), WIDTH'(0));

    // Sampling point: data bits only valid within +-1 clk of their centre
    base = words_rx;
    send_rand(NB, 1'b1);
    step(4);
    check("centre_words", WIDTH'(words_rx - base), WIDTH'(1));

    // 6: reset pulse in the middle of byte 9
    send_rand(8, 1'b0);
    rs232_rxd = 1'b0;
    step(DIV);
    rs232_rxd = 1'b1;
    step(DIV);
    rs232_rxd = 1'b0;
    step(DIV);
    check("t6_pre_nonzero", WIDTH'(data_out != '0), WIDTH'(1));
    reset_in_n = 1'b0;
    #1;
    check("t6_data_out",   data_out,           WIDTH'(0));
    check("t6_data_valid", WIDTH'(data_valid), WIDTH'(0));
    check("t6_frame_err",  WIDTH'(frame_err),  WIDTH'(0));
    rs232_rxd = 1'b1;
    step(2);
    reset_in_n = 1'b1;
    model_clear();
    step(2);
    base = words_rx;
    send_rand(NB, 1'b0);
    step(4);
    check("t6_words", WIDTH'(words_rx - base), WIDTH'(1));
    check("t6_queue", WIDTH'(exp_q.size()), WIDTH'(0));

    step(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
